// File: rtl/pwm_led_bank.sv
// ---------------------------------------------------------------------------
// pwm_led_bank
//   Multi-channel PWM LED driver. Each channel has a duty register written by
//   the core; the duty actually used by the comparator only changes at a PWM
//   period boundary, so a pin never sees a truncated or doubled pulse.
//
//   Optional build macro: PWM_LED_FADE_EN
//     Defined     : duty writes set a per-channel target; at every period
//                   boundary the active duty moves one step toward it.
//     Not defined : duty writes land in a shadow register which is copied to
//                   the active duty at the next period boundary.
//
// Ports
//   clk          in   1               system clock
//   reset        in   1               asynchronous, active-low reset
//   wr_en        in   1               one-cycle write strobe
//   wr_addr      in   ADDR_W          0..NUM_CH-1 duty[ch], NUM_CH prescale,
//                                     NUM_CH+1 invert mask
//   wr_data      in   PRESCALE_WIDTH  write data (low bits for duty / mask)
//   wr_err       out  1               pulse: write to an unmapped address
//   period_tick  out  1               pulse in the first cycle of a period
//   led_out      out  NUM_CH          registered PWM pins, polarity applied
//
// PRESCALE_WIDTH must be at least PWM_WIDTH and NUM_CH, since duty and mask
// values are taken from the low bits of wr_data.
// ---------------------------------------------------------------------------
module pwm_led_bank #(
  parameter int                        NUM_CH           = 4,
  parameter int                        PWM_WIDTH        = 8,
  parameter int                        PRESCALE_WIDTH   = 16,
  parameter logic [PRESCALE_WIDTH-1:0] DEFAULT_PRESCALE = '0,
  parameter logic [NUM_CH-1:0]         INVERT_DEFAULT   = '0,
  localparam int                       ADDR_W           = $clog2(NUM_CH + 2)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [PRESCALE_WIDTH-1:0] wr_data,
  output logic                      wr_err,
  output logic                      period_tick,
  output logic [NUM_CH-1:0]         led_out
);

  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] ADDR_INVERT   = ADDR_W'(NUM_CH + 1);

  logic [PRESCALE_WIDTH-1:0] pre_cnt_reg, pre_cnt_next;
  logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
  logic [PWM_WIDTH-1:0]      pwm_cnt_reg, pwm_cnt_next;
  logic [NUM_CH-1:0]         invert_reg, invert_next;
  logic [NUM_CH-1:0]         led_out_reg;
  logic [NUM_CH-1:0]         led_on;
  logic                      period_tick_reg;
  logic                      wr_err_reg;

  logic tick;
  logic boundary;
  logic prescale_wr;
  logic invert_wr;
  logic addr_bad;

  assign tick        = (pre_cnt_reg == prescale_reg);
  assign boundary    = tick && (pwm_cnt_reg == {PWM_WIDTH{1'b1}});
  assign prescale_wr = wr_en && (wr_addr == ADDR_PRESCALE);
  assign invert_wr   = wr_en && (wr_addr == ADDR_INVERT);
  assign addr_bad    = wr_en && (wr_addr > ADDR_INVERT);

  // Shared timebase: prescaler, period counter and polarity mask.
  always_comb begin
    prescale_next = prescale_reg;
    pre_cnt_next  = pre_cnt_reg + PRESCALE_WIDTH'(1);
    if (prescale_wr) begin
      // Restart the prescaler so the new rate begins from a clean count.
      prescale_next = wr_data;
      pre_cnt_next  = '0;
    end else if (tick) begin
      pre_cnt_next = '0;
    end
    pwm_cnt_next = tick ? pwm_cnt_reg + PWM_WIDTH'(1) : pwm_cnt_reg;
    // A mask write reaches the pins on the very next register update rather
    // than waiting for a period boundary.
    invert_next  = invert_wr ? wr_data[NUM_CH-1:0] : invert_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_reg     <= '0;
      prescale_reg    <= DEFAULT_PRESCALE;
      pwm_cnt_reg     <= '0;
      invert_reg      <= INVERT_DEFAULT;
      led_out_reg     <= INVERT_DEFAULT;
      period_tick_reg <= 1'b0;
      wr_err_reg      <= 1'b0;
    end else begin
      pre_cnt_reg     <= pre_cnt_next;
      prescale_reg    <= prescale_next;
      pwm_cnt_reg     <= pwm_cnt_next;
      invert_reg      <= invert_next;
      led_out_reg     <= led_on ^ invert_next;
      period_tick_reg <= boundary;
      wr_err_reg      <= addr_bad;
    end
  end

  // Per-channel duty handling and comparator.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [ADDR_W-1:0] CH_ADDR = ADDR_W'(gi);

      logic                 duty_wr;
      logic [PWM_WIDTH-1:0] wr_duty;
      logic [PWM_WIDTH-1:0] active_reg, active_next;

      assign duty_wr = wr_en && (wr_addr == CH_ADDR);
      assign wr_duty = wr_data[PWM_WIDTH-1:0];

`ifdef PWM_LED_FADE_EN
      logic [PWM_WIDTH-1:0] target_reg, target_next;
      logic [PWM_WIDTH-1:0] goal;

      // A write coinciding with a boundary steps toward the new target.
      assign goal = duty_wr ? wr_duty : target_reg;

      always_comb begin
        target_next = duty_wr ? wr_duty : target_reg;
        active_next = active_reg;
        if (boundary) begin
          if (active_reg < goal) begin
            active_next = active_reg + PWM_WIDTH'(1);
          end else if (active_reg > goal) begin
            active_next = active_reg - PWM_WIDTH'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          target_reg <= '0;
          active_reg <= '0;
        end else begin
          target_reg <= target_next;
          active_reg <= active_next;
        end
      end
`else
      logic [PWM_WIDTH-1:0] shadow_reg, shadow_next;

      always_comb begin
        shadow_next = duty_wr ? wr_duty : shadow_reg;
        active_next = active_reg;
        // Bypass the shadow so a write on the boundary cycle is not lost
        // for a whole period.
        if (boundary) begin
          active_next = shadow_next;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          shadow_reg <= shadow_next;
          active_reg <= active_next;
        end
      end
`endif

      // All-ones duty means fully on; the plain compare would leave one
      // dark tick per period.
      assign led_on[gi] = (active_reg == {PWM_WIDTH{1'b1}}) ||
                          (pwm_cnt_reg < active_reg);
    end
  endgenerate

  assign led_out     = led_out_reg;
  assign period_tick = period_tick_reg;
  assign wr_err      = wr_err_reg;

endmodule

// File: tb/tb_pwm_led_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_led_bank
//   Self-checking bench for pwm_led_bank (NUM_CH=3, PWM_WIDTH=4). A reference
//   model built from a free-running clock count, a tick count and plain
//   modulo arithmetic predicts led_out / period_tick / wr_err every cycle.
//   Compile with +define+PWM_LED_FADE_EN to exercise the fade build.
// ---------------------------------------------------------------------------
module tb_pwm_led_bank;

`ifdef PWM_LED_FADE_EN
  localparam bit FADE   = 1'b1;
  localparam int SETTLE = 16;
`else
  localparam bit FADE   = 1'b0;
  localparam int SETTLE = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_err;
  logic        period_tick;
  logic [2:0]  led_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pwm_led_bank #(
    .NUM_CH          (3),
    .PWM_WIDTH       (4),
    .PRESCALE_WIDTH  (16),
    .DEFAULT_PRESCALE(16'd0),
    .INVERT_DEFAULT  (3'b000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .period_tick(period_tick),
    .led_out    (led_out)
  );

  // ---------------- reference model ----------------
  int         m_since;      // clocks since the prescaler was last cleared
  int         m_prescale;
  int         m_ticks;      // ticks since reset; position = m_ticks % 16
  int         m_shadow[3];
  int         m_active[3];
  int         m_target[3];
  logic [2:0] m_inv;
  logic [2:0] m_led;
  logic       m_ptick;
  logic       m_err;

  function automatic bit m_tick_now();
    return ((m_since + 1) % (m_prescale + 1)) == 0;
  endfunction

  function automatic bit m_bnd_next();
    return m_tick_now() && ((m_ticks % 16) == 15);
  endfunction

  task automatic model_reset();
    m_since = 0; m_prescale = 0; m_ticks = 0;
    for (int c = 0; c < 3; c++) begin
      m_shadow[c] = 0; m_active[c] = 0; m_target[c] = 0;
    end
    m_inv = 3'b000; m_led = 3'b000; m_ptick = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [2:0] addr, input logic [15:0] data);
    bit tick, bnd, wr;
    int pos, d, goal;
    logic [2:0] inv_new;
    tick    = m_tick_now();
    pos     = m_ticks % 16;
    bnd     = tick && (pos == 15);
    inv_new = (we && addr == 3'd4) ? data[2:0] : m_inv;
    for (int c = 0; c < 3; c++)
      m_led[c] = ((m_active[c] == 15) || (pos < m_active[c])) ^ inv_new[c];
    m_ptick = bnd;
    m_err   = we && (addr >= 3'd5);
    d = int'(data[3:0]);
    for (int c = 0; c < 3; c++) begin
      wr = we && (int'(addr) == c);
      if (FADE) begin
        goal = wr ? d : m_target[c];
        if (bnd && m_active[c] < goal) m_active[c]++;
        else if (bnd && m_active[c] > goal) m_active[c]--;
        if (wr) m_target[c] = d;
      end else begin
        if (bnd) m_active[c] = wr ? d : m_shadow[c];
        if (wr) m_shadow[c] = d;
      end
    end
    m_inv = inv_new;
    if (we && addr == 3'd3) begin
      m_prescale = int'(data);
      m_since    = 0;
    end else begin
      m_since++;
    end
    if (tick) m_ticks++;
  endtask

  // Apply inputs for one clock edge and advance the model in step.
  task automatic drive_edge(input logic we, input logic [2:0] addr, input logic [15:0] data);
    wr_en = we; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    model_edge(we, addr, data);
  endtask

  task automatic idle_to_boundary(input int n);
    int seen = 0;
    for (int i = 0; i < n * 5000 && seen < n; i++) begin
      drive_edge(1'b0, 3'd0, 16'd0);
      if (m_ptick) seen++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first_pt = -1;
    reset = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'd0;
    model_reset();
    repeat (4) begin
      @(posedge clk); #1;
      vectors++;
      if (led_out !== 3'b000 || period_tick !== 1'b0 || wr_err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold led/pt/err got %b/%b/%b want 000/0/0", led_out, period_tick, wr_err);
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      drive_edge(1'b0, 3'd0, 16'd0);
      vectors++;
      if ({led_out, period_tick, wr_err} !== {m_led, m_ptick, m_err}) begin
        miscompares++;
        $display("FAIL reset_run cyc %0d led/pt/err got %b/%b/%b want %b/%b/%b", i, led_out, period_tick, wr_err, m_led, m_ptick, m_err);
      end
      if (period_tick === 1'b1 && first_pt < 0) first_pt = i;
    end
    vectors++;
    if (first_pt != 16) begin
      miscompares++;
      $display("FAIL first_period_tick got cycle %0d want 16", first_pt);
    end
  endtask

  task automatic test_async_reset();
    int first_pt = -1;
    for (int c = 0; c < 3; c++) drive_edge(1'b1, 3'(c), {12'($urandom), 4'd8});
    idle_to_boundary(SETTLE);
    repeat ($urandom_range(2, 6)) drive_edge(1'b0, 3'd0, 16'd0);
    vectors++;
    if (led_out !== 3'b111) begin
      miscompares++;
      $display("FAIL pre_reset_led got %b want 111", led_out);
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (led_out !== 3'b000 || period_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset led/pt got %b/%b want 000/0", led_out, period_tick);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      drive_edge(1'b0, 3'd0, 16'd0);
      vectors++;
      if ({led_out, period_tick, wr_err} !== {m_led, m_ptick, m_err}) begin
        miscompares++;
        $display("FAIL post_reset cyc %0d led/pt/err got %b/%b/%b want %b/%b/%b", i, led_out, period_tick, wr_err, m_led, m_ptick, m_err);
      end
      if (period_tick === 1'b1 && first_pt < 0) first_pt = i;
    end
    vectors++;
    if (first_pt != 16) begin
      miscompares++;
      $display("FAIL restart_period_tick got cycle %0d want 16", first_pt);
    end
  endtask

  task automatic test_duty_update();
    logic pre0;
    int cnt = 0;
    repeat ($urandom_range(1, 8)) drive_edge(1'b0, 3'd0, 16'd0);
    if (m_bnd_next()) drive_edge(1'b0, 3'd0, 16'd0);
    pre0 = led_out[0];
    drive_edge(1'b1, 3'd0, {12'($urandom), 4'd4});
    for (int i = 0; i < 40 && !m_ptick; i++) begin
      vectors++;
      if (led_out[0] !== pre0 || {led_out, period_tick} !== {m_led, m_ptick}) begin
        miscompares++;
        $display("FAIL duty_hold led/pt got %b/%b want %b/%b", led_out, period_tick, m_led, m_ptick);
      end
      drive_edge(1'b0, 3'd0, 16'd0);
    end
    if (SETTLE > 1) idle_to_boundary(SETTLE - 1);
    for (int i = 0; i < 16; i++) begin
      drive_edge(1'b0, 3'd0, 16'd0);
      vectors++;
      if ({led_out, period_tick} !== {m_led, m_ptick}) begin
        miscompares++;
        $display("FAIL duty_run led/pt got %b/%b want %b/%b", led_out, period_tick, m_led, m_ptick);
      end
      if (led_out[0] === 1'b1) cnt++;
    end
    vectors++;
    if (cnt != 4) begin
      miscompares++;
      $display("FAIL duty4_high_clks got %0d want 4", cnt);
    end
  endtask

  task automatic test_extremes();
    drive_edge(1'b1, 3'd1, {12'($urandom), 4'd0});
    drive_edge(1'b1, 3'd2, {12'($urandom), 4'd15});
    idle_to_boundary(SETTLE);
    for (int i = 0; i < 16; i++) begin
      drive_edge(1'b0, 3'd0, 16'd0);
      vectors++;
      if (led_out[1] !== 1'b0 || led_out[2] !== 1'b1 || led_out !== m_led) begin
        miscompares++;
        $display("FAIL extremes led got %b want x10 (model %b)", led_out, m_led);
      end
    end
  endtask

  task automatic test_boundary_write();
    int cnt = 0;
    for (int i = 0; i < 64 && !m_bnd_next(); i++) drive_edge(1'b0, 3'd0, 16'd0);
    drive_edge(1'b1, 3'd0, 16'd9);
    for (int i = 0; i < 16; i++) begin
      drive_edge(1'b0, 3'd0, 16'd0);
      vectors++;
      if ({led_out, period_tick} !== {m_led, m_ptick}) begin
        miscompares++;
        $display("FAIL bnd_write_run led/pt got %b/%b want %b/%b", led_out, period_tick, m_led, m_ptick);
      end
      if (led_out[0] === 1'b1) cnt++;
    end
    vectors++;
    if (cnt != (FADE ? 5 : 9)) begin
      miscompares++;
      $display("FAIL bnd_write_high_clks got %0d want %0d", cnt, FADE ? 5 : 9);
    end
  endtask

  task automatic test_prescale();
    int ticks[$];
    int cnt = 0;
    drive_edge(1'b1, 3'd0, {12'($urandom), 4'd4});
    idle_to_boundary(SETTLE + 1);
    drive_edge(1'b1, 3'd3, 16'd2);
    for (int i = 0; i < 200 && ticks.size() < 3; i++) begin
      drive_edge(1'b0, 3'd0, 16'd0);
      vectors++;
      if ({led_out, period_tick} !== {m_led, m_ptick}) begin
        miscompares++;
        $display("FAIL prescale_run led/pt got %b/%b want %b/%b", led_out, period_tick, m_led, m_ptick);
      end
      if (ticks.size() == 2 && led_out[0] === 1'b1) cnt++;
      if (period_tick === 1'b1) ticks.push_back(i);
    end
    vectors++;
    if (ticks.size() < 3) begin
      miscompares++;
      $display("FAIL prescale_timeout got %0d period ticks want 3", ticks.size());
    end else begin
      vectors++;
      if (ticks[2] - ticks[1] != 48) begin
        miscompares++;
        $display("FAIL prescale_spacing got %0d want 48", ticks[2] - ticks[1]);
      end
      if (cnt != 12) begin
        miscompares++;
        $display("FAIL prescale_high_clks got %0d want 12", cnt);
      end
    end
    drive_edge(1'b1, 3'd3, 16'd0);
  endtask

  task automatic test_invert_err();
    for (int c = 0; c < 3; c++) drive_edge(1'b1, 3'(c), 16'd0);
    idle_to_boundary(SETTLE);
    drive_edge(1'b1, 3'd4, {13'($urandom), 3'b101});
    vectors++;
    if (led_out !== 3'b101 || led_out !== m_led) begin
      miscompares++;
      $display("FAIL invert_next_clk led got %b want 101", led_out);
    end
    for (int a = 5; a <= 7; a++) begin
      drive_edge(1'b1, 3'(a), 16'($urandom));
      vectors++;
      if (wr_err !== 1'b1) begin
        miscompares++;
        $display("FAIL wr_err_pulse addr %0d got %b want 1", a, wr_err);
      end
    end
    for (int i = 0; i < 20; i++) begin
      drive_edge(1'b0, 3'd0, 16'd0);
      vectors++;
      if (led_out !== 3'b101 || wr_err !== 1'b0 || period_tick !== m_ptick) begin
        miscompares++;
        $display("FAIL unmapped_no_effect led/err/pt got %b/%b/%b want 101/0/%b", led_out, wr_err, period_tick, m_ptick);
      end
    end
    drive_edge(1'b1, 3'd4, 16'd0);
  endtask

`ifdef PWM_LED_FADE_EN
  task automatic test_fade();
    int exp_cnt[5] = '{1, 2, 3, 2, 1};
    int cnt;
    for (int w = 0; w < 5; w++) begin
      if (w == 0 || w == 3) begin
        drive_edge(1'b1, 3'd0, (w == 0) ? 16'd3 : 16'd1);
        for (int i = 0; i < 40 && !m_ptick; i++) drive_edge(1'b0, 3'd0, 16'd0);
      end
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        drive_edge(1'b0, 3'd0, 16'd0);
        vectors++;
        if ({led_out, period_tick} !== {m_led, m_ptick}) begin
          miscompares++;
          $display("FAIL fade_run led/pt got %b/%b want %b/%b", led_out, period_tick, m_led, m_ptick);
        end
        if (led_out[0] === 1'b1) cnt++;
      end
      vectors++;
      if (cnt != exp_cnt[w]) begin
        miscompares++;
        $display("FAIL fade_period %0d high clks got %0d want %0d", w, cnt, exp_cnt[w]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic we;
      logic [2:0] a;
      logic [15:0] d;
      we = ($urandom_range(0, 1) == 1);
      a  = 3'($urandom_range(0, 7));
      d  = (a == 3'd3) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      drive_edge(we, a, d);
      vectors++;
      if ({led_out, period_tick, wr_err} !== {m_led, m_ptick, m_err}) begin
        miscompares++;
        $display("FAIL random cyc %0d led/pt/err got %b/%b/%b want %b/%b/%b", i, led_out, period_tick, wr_err, m_led, m_ptick, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_duty_update();
    test_extremes();
    test_boundary_write();
    test_prescale();
    test_invert_err();
`ifdef PWM_LED_FADE_EN
    test_fade();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
